// File: rtl/counter_share_pkg.sv
// counter_share_pkg: shared types, defaults and round-robin pick for counter_share_sched
package counter_share_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;
  // Descending scan so the last hit is the lowest offset from ptr.
  function automatic pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    pick_t p;
    int j;
    p = '0;
    for (int k = 7; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if (k < n && req[j[2:0]]) begin
        p.valid = 1'b1;
        p.idx   = j[2:0];
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/shared_counter.sv
// shared_counter: WIDTH-bit up counter with sync clear and enable, async active-high reset
module shared_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en) r_count <= r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/counter_share_sched.sv
// counter_share_sched: round-robin time-sharing of one up counter among NUM_REQ requesters.
// Define COUNTER_SHARE_ABORT_EN to let the owner abort its interval by dropping req.
module counter_share_sched
  import counter_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] target,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count
);
  state_t             r_state, w_next;
  logic [NUM_REQ-1:0] r_gnt, r_done;
  logic [WIDTH-1:0]   r_tgt;
  logic [2:0]         r_owner, r_ptr, w_ptr_nxt;
  logic [7:0]         w_req8;
  logic               w_clr, w_en, w_abort;
  pick_t              w_pick;
  always_comb begin
    w_req8 = '0;
    w_req8[NUM_REQ-1:0] = req;
  end
  assign w_pick    = rr_pick(w_req8, r_ptr, NUM_REQ);
  assign w_ptr_nxt = (w_pick.idx == 3'(NUM_REQ - 1)) ? 3'd0 : w_pick.idx + 3'd1;
`ifdef COUNTER_SHARE_ABORT_EN
  assign w_abort = !w_req8[r_owner];
`else
  assign w_abort = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = w_pick.valid ? RUN : IDLE;
        w_clr  = w_pick.valid;
      end
      RUN: begin
        w_next = w_abort ? IDLE : (count == r_tgt) ? DONE : RUN;
        w_en   = !w_abort && count != r_tgt;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_tgt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= '0;
      if (r_state == IDLE && w_pick.valid) begin
        r_gnt   <= NUM_REQ'(1) << w_pick.idx;
        r_tgt   <= target[w_pick.idx*WIDTH +: WIDTH];
        r_owner <= w_pick.idx;
        r_ptr   <= w_ptr_nxt;
      end
      if (r_state == RUN && w_next != RUN) r_gnt <= '0;
      if (r_state == RUN && w_next == DONE) r_done <= NUM_REQ'(1) << r_owner;
    end
  shared_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_count(count)
  );
  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_counter_share_sched.sv
// tb_counter_share_sched: directed and random checks of counter_share_sched against a transaction-level model
module tb_counter_share_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] target;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [15:0] count;
  logic [15:0] tg [4];
  int          n_assert = 0;
  int          n_fail = 0;
  int          m_ptr = 0;

  always #5 clk = ~clk;

  always_comb begin
    target = '0;
    for (int i = 0; i < 4; i++) target[i*16 +: 16] = tg[i];
  end

  counter_share_sched #(.NUM_REQ(4), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req(req), .target(target),
    .gnt(gnt), .done(done), .busy(busy), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (((r >> ((p + k) % 4)) & 4'd1) != 4'd0) return (p + k) % 4;
    return -1;
  endfunction

  task automatic idle_chk(input string tag, input logic [15:0] cnt);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_cnt"}, 32'(count), 32'(cnt));
  endtask

  // Called at a negedge with the DUT idle; one full grant/run/done/idle transaction.
  task automatic txn(input string tag, input logic [3:0] r);
    int w;
    int t;
    req = r;
    w = pick(r, m_ptr);
    m_ptr = (w + 1) % 4;
    t = int'(tg[w]);
    for (int k = 0; k <= t; k++) begin
      @(negedge clk);
      chk({tag, "_run_gnt"}, 32'(gnt), 32'(1) << w);
      chk({tag, "_run_cnt"}, 32'(count), 32'(k));
      if (k == 0 || k == t) begin
        chk({tag, "_run_done"}, 32'(done), 0);
        chk({tag, "_run_busy"}, 32'(busy), 1);
      end
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'(1) << w);
    chk({tag, "_done_gnt"}, 32'(gnt), 0);
    chk({tag, "_done_cnt"}, 32'(count), 32'(t));
    chk({tag, "_done_busy"}, 32'(busy), 1);
    @(negedge clk);
    idle_chk({tag, "_idle"}, 16'(t));
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tg[i] = '0;
    #1;
    idle_chk("reset", 16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) tg[i] = 16'd2;
    for (int i = 0; i < 5; i++) txn("rr", 4'b1111);

    tg[0] = 16'd5;
    txn("single", 4'b0001);
    @(negedge clk);
    idle_chk("single_hold", 16'd5);

    tg[2] = 16'd0;
    txn("zero", 4'b0100);

    tg[0] = 16'd10;
    req = 4'b0001;
    m_ptr = 1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("abort_gnt", 32'(gnt), 1);
      chk("abort_cnt", 32'(count), 32'(k));
    end
    req = '0;
`ifdef COUNTER_SHARE_ABORT_EN
    @(negedge clk);
    idle_chk("abort_stop", 16'd3);
    @(negedge clk);
    idle_chk("abort_idle", 16'd3);
`else
    for (int k = 4; k <= 10; k++) begin
      @(negedge clk);
      chk("noabort_gnt", 32'(gnt), 1);
      chk("noabort_cnt", 32'(count), 32'(k));
    end
    @(negedge clk);
    chk("noabort_done", 32'(done), 1);
    chk("noabort_dgnt", 32'(gnt), 0);
    @(negedge clk);
    idle_chk("noabort_idle", 16'd10);
`endif

    tg[0] = 16'd20;
    req = 4'b0001;
    m_ptr = 1;
    for (int k = 0; k <= 7; k++) @(negedge clk);
    chk("rst_pre_cnt", 32'(count), 7);
    chk("rst_pre_gnt", 32'(gnt), 1);
    #2 reset = 1'b1;
    #1;
    idle_chk("rst_async", 16'd0);
    #1 reset = 1'b0;
    m_ptr = 0;
    tg[0] = 16'd3;
    tg[1] = 16'd4;
    txn("rst_after0", 4'b0011);
    txn("rst_after1", 4'b0011);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) tg[i] = 16'($urandom_range(0, 7));
      txn("rand", 4'($urandom_range(1, 15)));
    end

    tg[1] = 16'hFFFF;
    txn("max", 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_share_sched.md
Name: counter_share_sched

Overview:
- Time-shares one WIDTH-bit up counter between NUM_REQ requesters that each need a timed interval.
- Each cycle in IDLE, a round-robin arbiter picks one requester, latches its target, clears the counter and lets it count up to the target.
- The block then pulses that requester's done and re-arbitrates.
- Sits between several control FSMs and a single shared counter resource, so no requester needs a private counter.

Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- WIDTH, 16: counter and target width in bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  level request per requester; held until done or abandon.
- target  input  NUM_REQ*WIDTH  per-requester terminal count; slice i = target[i*WIDTH +: WIDTH]; sampled only at grant.
- gnt  output  NUM_REQ  one-hot grant; high while that requester owns the counter.
- done  output  NUM_REQ  one-cycle pulse when the owner's interval completes.
- busy  output  1  high whenever the FSM is not in IDLE.
- count  output  WIDTH  current shared counter value.

Behaviour:
- Reset (async, active-high): state=IDLE, gnt=0, done=0, busy=0, count=0, rr_ptr=0, latched target=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when any req bit is set.
  - Winner = first set req bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - At the next edge: gnt[winner]=1, count=0, tgt_q=target slice of winner, owner index stored, rr_ptr=(winner+1) mod NUM_REQ.
  - Latency: req rising in IDLE at edge t gives gnt at edge t+1.
- RUN, count != tgt_q: count increments by 1 per cycle.
- RUN, count == tgt_q: next edge enters DONE with gnt=0, done[owner]=1, count held at tgt_q.
  - gnt is high for exactly tgt_q+1 cycles (count 0..tgt_q).
  - tgt_q=0 gives one RUN cycle, then done.
- DONE: lasts one cycle. done is forced back to 0, state goes to IDLE, count held.
  - A requester still asserting req is re-arbitrated fairly; rr_ptr has already moved past it.
- Back-to-back: one IDLE cycle always separates grants. Minimum period per grant = tgt_q+3 cycles.
- Owner drops req during RUN: handled per Optional Feature.
- Non-owner req changes during RUN: ignored. A new target value has no effect once latched.
- Wrap-around: impossible in normal operation because tgt_q <= 2^WIDTH-1 and counting stops at tgt_q. The counter arithmetic is modulo 2^WIDTH.
- Simultaneous requests: exactly one grant. Priority rotates per rr_ptr.
- Reset mid-RUN: immediate return to reset values, no done pulse, rr_ptr=0.
- Invariants: gnt and done are never both high; gnt is at most one-hot; done is at most one-hot.

Optional Feature:
- Macro: COUNTER_SHARE_ABORT_EN.
- Defined: the owner deasserting req in RUN aborts the interval. Next edge: gnt=0, state=IDLE, no done pulse, count holds its value.
- Undefined: req deassertion by the owner is ignored. The interval runs to tgt_q and done still pulses.

Decomposition:
- Package counter_share_pkg:
  - state enum (IDLE, RUN, DONE), 2-bit encoding.
  - Default NUM_REQ/WIDTH constants.
  - Round-robin pick function (req vector, pointer -> index, valid).
- Sub-module shared_counter: WIDTH-bit register with sync clear, enable, async active-high reset; instantiated once.
- Arbiter and FSM stay in the top module.

Test Plan:
- Single request: req=0001, target0=5 -> gnt[0] high 6 cycles with count 0..5; done[0] pulses 1 cycle; count stays 5; busy low after DONE.
- Zero target: req=0100, target2=0 -> gnt[2] for 1 cycle at count=0, then done[2] pulse.
- Round-robin fairness: req=1111 held, all targets=2 -> grants in order 0,1,2,3,0. Each grant is 3 cycles, separated by DONE+IDLE.
- Abort: with COUNTER_SHARE_ABORT_EN, req0 dropped at count=3 of target 10 -> gnt[0]=0 next edge, no done, IDLE. Without the macro -> counts to 10 and done[0] pulses.
- Async reset mid-RUN at count=7 -> gnt, done, busy, count all 0 immediately, with no clock edge. A subsequent req=0010 alongside req0 gets req0 granted first (rr_ptr=0).
- Max target: target1=16'hFFFF -> count reaches FFFF without wrapping; done[1] pulses after 65536 grant cycles.
